// File: rtl/lcd_cmd_sequencer.sv
// Host-side command scheduler: buffers host image commands and issues them one at a time
// to the LCD controller over cmd/cmd_valid/busy, halting after a WRITE completes.
module lcd_cmd_sequencer #(
  parameter int DEPTH = 8,
  parameter int TMO   = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               host_cmd,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic                     lcd_busy,
  input  logic                     lcd_done,
  output logic [2:0]               cmd,
  output logic                     cmd_valid,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic [CNT_W-1:0]         issued_cnt,
  output logic                     seq_done,
  output logic                     err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TMO);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  typedef enum logic [2:0] {
    INIT, IDLE, ISSUE, WAIT_HI, WAIT_LO, WAIT_DONE, DONE
  } state_t;

  state_t          state;
  logic [2:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     cnt_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic            is_write;
  logic            done_seen;
  logic            push, pop;

  assign push = host_valid && host_ready;
  assign pop  = (state == ISSUE);

  always_comb begin
    cnt_nxt = fifo_cnt;
    if (push && !pop)
      cnt_nxt = fifo_cnt + 1'b1;
    else if (!push && pop)
      cnt_nxt = fifo_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= host_cmd;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= INIT;
      cmd         <= '0;
      cmd_valid   <= 1'b0;
      host_ready  <= 1'b0;
      issued_cnt  <= '0;
      seq_done    <= 1'b0;
      err_timeout <= 1'b0;
      is_write    <= 1'b0;
      done_seen   <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      cmd_valid  <= 1'b0;
      host_ready <= (cnt_nxt < FULL);
      case (state)
        INIT: if (!lcd_busy) state <= IDLE;
        IDLE: begin
          if (fifo_cnt != '0 && !lcd_busy) begin
            state     <= ISSUE;
            cmd_valid <= 1'b1;
            cmd       <= mem[rd_ptr];
          end
        end
        ISSUE: begin
          state     <= WAIT_HI;
          is_write  <= (cmd == 3'd0);
          tmo_cnt   <= '0;
          done_seen <= 1'b0;
          if (issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
        end
        WAIT_HI: begin
          if (lcd_busy) begin
            state <= WAIT_LO;
          end else if (tmo_cnt == TMO_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          // A done arriving while busy is still high must not be lost.
          if (lcd_done) done_seen <= 1'b1;
          if (!lcd_busy) state <= is_write ? WAIT_DONE : IDLE;
        end
        WAIT_DONE: begin
          if (lcd_done || done_seen) begin
            state      <= DONE;
            seq_done   <= 1'b1;
            host_ready <= 1'b0;
          end
        end
        DONE:    host_ready <= 1'b0;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with a simple controller model (1-cycle busy,
// done 64 cycles after a WRITE) and a strobe monitor.
module tb_lcd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  host_cmd;
  logic        host_valid;
  logic        host_ready;
  logic        lcd_busy;
  logic        lcd_done;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic [3:0]  fifo_cnt;
  logic [15:0] issued_cnt;
  logic        seq_done;
  logic        err_timeout;

  lcd_cmd_sequencer #(.DEPTH(8), .TMO(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
    .host_ready(host_ready), .lcd_busy(lcd_busy), .lcd_done(lcd_done), .cmd(cmd),
    .cmd_valid(cmd_valid), .fifo_cnt(fifo_cnt), .issued_cnt(issued_cnt),
    .seq_done(seq_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       force_busy, model_en, model_busy, model_done;
  logic [6:0] dcnt;
  logic       prev_vld;
  logic [2:0] issued_q[$];
  int         times_q[$];

  assign lcd_busy = force_busy | model_busy;
  assign lcd_done = model_done;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: busy for one cycle after each strobe, done 64 cycles after a WRITE.
  always @(posedge clk) begin
    if (!reset) begin
      model_busy <= 1'b0;
      model_done <= 1'b0;
      dcnt       <= '0;
    end else begin
      model_busy <= model_en && cmd_valid;
      model_done <= 1'b0;
      if (model_en && cmd_valid && cmd == 3'd0)
        dcnt <= 7'd64;
      else if (dcnt != 0) begin
        dcnt <= dcnt - 1'b1;
        if (dcnt == 7'd1) model_done <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmd_valid) begin
      issued_q.push_back(cmd);
      times_q.push_back(cyc);
      chk("strobe_single_cycle", {31'd0, prev_vld}, 32'd0);
    end
    prev_vld = cmd_valid;
  end

  task automatic do_reset(input logic busy_lvl);
    @(negedge clk);
    reset = 1'b0; host_valid = 1'b0; force_busy = busy_lvl; model_en = 1'b0;
    repeat (2) @(negedge clk);
    issued_q.delete(); times_q.delete();
    reset = 1'b1;
  endtask

  task automatic push(input logic [2:0] c);
    int n = 0;
    host_cmd = c; host_valid = 1'b1;
    while (!host_ready && n < 100) begin @(negedge clk); n++; end
    if (!host_ready) chk("push_ready_timeout", {31'd0, host_ready}, 32'd1);
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int k, input int budget);
    int n = 0;
    while (issued_q.size() < k && n < budget) begin @(negedge clk); n++; end
    chk("strobe_count", issued_q.size(), k);
  endtask

  task automatic wait_vld(input int budget);
    int n = 0;
    while (!cmd_valid && n < budget) begin @(negedge clk); n++; end
    chk("strobe_seen", {31'd0, cmd_valid}, 32'd1);
  endtask

  typedef struct {
    logic [2:0]  c;
    logic [2:0]  exp_cmd;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t tbl[6];
  logic [2:0] full_seq[8];

  initial begin
    tbl[0] = '{3'd4, 3'd4, 16'd3};
    tbl[1] = '{3'd5, 3'd5, 16'd4};
    tbl[2] = '{3'd6, 3'd6, 16'd5};
    tbl[3] = '{3'd7, 3'd7, 16'd6};
    tbl[4] = '{3'd2, 3'd2, 16'd7};
    tbl[5] = '{3'd1, 3'd1, 16'd8};
    full_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    prev_vld = 1'b0;
    reset = 1'b0; host_valid = 1'b0; host_cmd = '0; force_busy = 1'b0; model_en = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 0);
    chk("rst_cmd", {29'd0, cmd}, 0);
    chk("rst_host_ready", {31'd0, host_ready}, 0);
    chk("rst_fifo_cnt", {28'd0, fifo_cnt}, 0);
    chk("rst_issued_cnt", {16'd0, issued_cnt}, 0);
    chk("rst_seq_done", {31'd0, seq_done}, 0);
    chk("rst_err_timeout", {31'd0, err_timeout}, 0);

    // Busy held through INIT: nothing issued until release, then UP, LEFT
    do_reset(1'b1);
    push(3'd1); push(3'd3);
    repeat (61) @(negedge clk);
    chk("init_no_issue", issued_q.size(), 0);
    chk("init_fifo_cnt", {28'd0, fifo_cnt}, 2);
    force_busy = 1'b0; model_en = 1'b1;
    wait_strobes(2, 100);
    chk("init_cmd0", {29'd0, issued_q[0]}, 1);
    chk("init_cmd1", {29'd0, issued_q[1]}, 3);

    // Table: one command at a time, check issued value and running count
    for (int i = 0; i < 6; i++) begin
      push(tbl[i].c);
      wait_strobes(3 + i, 60);
      repeat (2) @(negedge clk);
      chk("tbl_cmd", {29'd0, issued_q[2 + i]}, {29'd0, tbl[i].exp_cmd});
      chk("tbl_issued_cnt", {16'd0, issued_cnt}, {16'd0, tbl[i].exp_cnt});
    end

    // Fill FIFO in INIT, reject 9th, pop-while-full push rejected, drain in order
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) push(full_seq[i]);
    chk("full_host_ready", {31'd0, host_ready}, 0);
    chk("full_fifo_cnt", {28'd0, fifo_cnt}, 8);
    host_cmd = 3'd6; host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
    chk("ninth_ignored", {28'd0, fifo_cnt}, 8);
    chk("full_no_issue", issued_q.size(), 0);
    force_busy = 1'b0; model_en = 1'b1;
    wait_vld(20);
    chk("pop_full_ready", {31'd0, host_ready}, 0);
    host_cmd = 3'd2; host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
    chk("pop_full_cnt", {28'd0, fifo_cnt}, 7);
    chk("pop_full_ready_after", {31'd0, host_ready}, 1);
    wait_strobes(8, 200);
    for (int i = 0; i < 8; i++)
      chk("drain_order", {29'd0, issued_q[i]}, {29'd0, full_seq[i]});
    for (int i = 1; i < 8; i++)
      chk("issue_spacing", times_q[i] - times_q[i-1], 4);
    repeat (20) @(negedge clk);
    chk("drain_total", issued_q.size(), 8);
    chk("drain_fifo_cnt", {28'd0, fifo_cnt}, 0);

    // AVG, MIRX, WRITE: halt after done
    do_reset(1'b0);
    model_en = 1'b1;
    push(3'd5); push(3'd6); push(3'd0);
    wait_strobes(3, 100);
    chk("write_cmd", {29'd0, issued_q[2]}, 0);
    repeat (30) @(negedge clk);
    chk("done_not_early", {31'd0, seq_done}, 0);
    for (int n = 0; n < 200 && !seq_done; n++) @(negedge clk);
    chk("seq_done", {31'd0, seq_done}, 1);
    chk("done_issued_cnt", {16'd0, issued_cnt}, 3);
    chk("done_host_ready", {31'd0, host_ready}, 0);
    chk("done_cmd_hold", {29'd0, cmd}, 0);
    host_cmd = 3'd1; host_valid = 1'b1;
    repeat (3) @(negedge clk);
    host_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("done_push_rejected", {28'd0, fifo_cnt}, 0);
    chk("done_no_more_issue", issued_q.size(), 3);

    // Busy never rises after RIGHT: timeout, then LEFT still issued
    do_reset(1'b0);
    push(3'd4); push(3'd3);
    wait_vld(20);
    begin
      int n = 0;
      while (!err_timeout && n < 40) begin @(negedge clk); n++; end
      chk("tmo_latency", n, 17);
    end
    model_en = 1'b1;
    wait_strobes(2, 40);
    chk("tmo_next_cmd", {29'd0, issued_q[1]}, 3);
    repeat (4) @(negedge clk);
    chk("tmo_sticky", {31'd0, err_timeout}, 1);
    chk("tmo_issued_cnt", {16'd0, issued_cnt}, 2);

    // Reset asserted in WAIT_LO with three entries still queued
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) push(full_seq[i]);
    force_busy = 1'b0;
    wait_vld(20);
    @(negedge clk);
    force_busy = 1'b1;
    @(negedge clk);
    chk("wlo_fifo_cnt", {28'd0, fifo_cnt}, 3);
    chk("wlo_issued_cnt", {16'd0, issued_cnt}, 1);
    reset = 1'b0;
    #1;
    chk("arst_fifo_cnt", {28'd0, fifo_cnt}, 0);
    chk("arst_issued_cnt", {16'd0, issued_cnt}, 0);
    chk("arst_host_ready", {31'd0, host_ready}, 0);
    chk("arst_cmd", {29'd0, cmd}, 0);
    @(negedge clk);
    force_busy = 1'b0;
    reset = 1'b1;
    issued_q.delete(); times_q.delete();
    repeat (10) @(negedge clk);
    chk("post_rst_no_issue", issued_q.size(), 0);
    chk("post_rst_fifo_cnt", {28'd0, fifo_cnt}, 0);
    model_en = 1'b1;
    push(3'd7);
    wait_strobes(1, 40);
    chk("post_rst_cmd", {29'd0, issued_q[0]}, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
